// File: rtl/fetch_decode_buffer.sv
// rtl/fetch_decode_buffer.sv - two-entry fetch-to-decode instruction buffer with flush and NOP bubble
// Optional bubble-cycle counter enabled by defining FDB_BUBBLE_CNT_EN.
module fetch_decode_buffer (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] instrF,
   input  logic [15:0] incPCF,
   input  logic        errF,
   input  logic        validF,
   output logic        readyF,
   output logic [15:0] instrD,
   output logic [15:0] incPCD,
   output logic        errD,
   output logic        validD,
   input  logic        stallD,
   input  logic        flush,
   output logic [1:0]  occupancy,
   output logic [15:0] bubbleCnt
);

   logic [15:0] instr_q [2];
   logic [15:0] instr_d [2];
   logic [15:0] pc_q [2];
   logic [15:0] pc_d [2];
   logic [1:0]  err_q;
   logic [1:0]  err_d;
   logic        rd_ptr_q, rd_ptr_d;
   logic        wr_ptr_q, wr_ptr_d;
   logic [1:0]  count_q, count_d;
   logic        push;
   logic        pop;

   // All decode-side outputs come from registered state only.
   assign readyF    = (count_q != 2'd2);
   assign validD    = (count_q != 2'd0);
   assign occupancy = count_q;
   assign instrD    = validD ? instr_q[rd_ptr_q] : 16'h0800;
   assign incPCD    = validD ? pc_q[rd_ptr_q]    : 16'h0000;
   assign errD      = validD ? err_q[rd_ptr_q]   : 1'b0;

   always_comb begin
      push     = validF & readyF & ~flush;
      pop      = validD & ~stallD & ~flush;
      instr_d  = instr_q;
      pc_d     = pc_q;
      err_d    = err_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;

      if (push) begin
         instr_d[wr_ptr_q] = instrF;
         pc_d[wr_ptr_q]    = incPCF;
         err_d[wr_ptr_q]   = errF;
         wr_ptr_d          = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end

      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase

      if (flush) begin
         count_d  = 2'd0;
         rd_ptr_d = 1'b0;
         wr_ptr_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         count_q  <= 2'd0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
      end else begin
         count_q  <= count_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
      end
   end

   // Entry payload needs no reset; validity is tracked by count alone.
   always_ff @(posedge clk) begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
   end

`ifdef FDB_BUBBLE_CNT_EN
   logic [15:0] bubble_cnt_q, bubble_cnt_d;

   always_comb begin
      bubble_cnt_d = bubble_cnt_q;
      if (!validD && !stallD && (bubble_cnt_q != 16'hFFFF)) begin
         bubble_cnt_d = bubble_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         bubble_cnt_q <= 16'h0000;
      end else begin
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign bubbleCnt = bubble_cnt_q;
`else
   assign bubbleCnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// tb/tb_fetch_decode_buffer.sv - self-checking bench for fetch_decode_buffer (vectors, corner sequences, random vs queue model)
module tb_fetch_decode_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] instrF;
   logic [15:0] incPCF;
   logic        errF;
   logic        validF;
   logic        readyF;
   logic [15:0] instrD;
   logic [15:0] incPCD;
   logic        errD;
   logic        validD;
   logic        stallD;
   logic        flush;
   logic [1:0]  occupancy;
   logic [15:0] bubbleCnt;

   int pass_cnt  = 0;
   int check_cnt = 0;

   logic [32:0] mq [$];
   logic [15:0] mbub = 16'h0000;

   fetch_decode_buffer dut (
      .clk(clk), .rst(rst), .instrF(instrF), .incPCF(incPCF), .errF(errF),
      .validF(validF), .readyF(readyF), .instrD(instrD), .incPCD(incPCD),
      .errD(errD), .validD(validD), .stallD(stallD), .flush(flush),
      .occupancy(occupancy), .bubbleCnt(bubbleCnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        r;
      logic        vf;
      logic [15:0] ins;
      logic [15:0] pc;
      logic        e;
      logic        st;
      logic        fl;
      logic        ev;
      logic [15:0] ei;
      logic [15:0] ep;
      logic        ee;
      logic [1:0]  eo;
      logic        er;
   } vec_t;

   vec_t tbl [18];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      check_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Drive one cycle, advance the reference model at the edge, return at the following negedge.
   task automatic step(input logic r, input logic vf, input logic [15:0] ins, input logic [15:0] pcv,
                       input logic e, input logic st, input logic fl);
      int sz;
      rst = r; validF = vf; instrF = ins; incPCF = pcv; errF = e; stallD = st; flush = fl;
      @(posedge clk);
      sz = mq.size();
      if (!r) begin
         mq.delete();
         mbub = 16'h0000;
      end else begin
`ifdef FDB_BUBBLE_CNT_EN
         if (sz == 0 && !st && mbub != 16'hFFFF) mbub = mbub + 16'd1;
`endif
         if (fl) mq.delete();
         else begin
            if (sz > 0 && !st) void'(mq.pop_front());
            if (vf && sz < 2) mq.push_back({e, pcv, ins});
         end
      end
      @(negedge clk);
   endtask

   task automatic check_model(input string tag);
      logic [32:0] h;
      h = (mq.size() > 0) ? mq[0] : {1'b0, 16'h0000, 16'h0800};
      chk({tag, ".validD"},    {31'd0, validD},    {31'd0, mq.size() > 0});
      chk({tag, ".instrD"},    {16'd0, instrD},    {16'd0, h[15:0]});
      chk({tag, ".incPCD"},    {16'd0, incPCD},    {16'd0, h[31:16]});
      chk({tag, ".errD"},      {31'd0, errD},      {31'd0, h[32]});
      chk({tag, ".readyF"},    {31'd0, readyF},    {31'd0, mq.size() < 2});
      chk({tag, ".occupancy"}, {30'd0, occupancy}, mq.size());
      chk({tag, ".bubbleCnt"}, {16'd0, bubbleCnt}, {16'd0, mbub});
   endtask

   initial begin
      //               r  vf  ins       pc        e  st fl   ev ei        ep        ee eo    er
      tbl[0]  = '{1'b0,1'b1,16'h1111,16'h9999,1'b0,1'b0,1'b0, 1'b0,16'h0800,16'h0000,1'b0,2'd0,1'b1};
      tbl[1]  = '{1'b0,1'b1,16'h1111,16'h9999,1'b0,1'b0,1'b0, 1'b0,16'h0800,16'h0000,1'b0,2'd0,1'b1};
      tbl[2]  = '{1'b1,1'b1,16'h4101,16'h0102,1'b0,1'b0,1'b0, 1'b1,16'h4101,16'h0102,1'b0,2'd1,1'b1};
      tbl[3]  = '{1'b1,1'b1,16'h4202,16'h0104,1'b0,1'b0,1'b0, 1'b1,16'h4202,16'h0104,1'b0,2'd1,1'b1};
      tbl[4]  = '{1'b1,1'b1,16'h4303,16'h0106,1'b0,1'b0,1'b0, 1'b1,16'h4303,16'h0106,1'b0,2'd1,1'b1};
      tbl[5]  = '{1'b1,1'b0,16'h0000,16'h0000,1'b0,1'b0,1'b0, 1'b0,16'h0800,16'h0000,1'b0,2'd0,1'b1};
      tbl[6]  = '{1'b1,1'b1,16'h5101,16'h0202,1'b0,1'b1,1'b0, 1'b1,16'h5101,16'h0202,1'b0,2'd1,1'b1};
      tbl[7]  = '{1'b1,1'b1,16'h5202,16'h0204,1'b0,1'b1,1'b0, 1'b1,16'h5101,16'h0202,1'b0,2'd2,1'b0};
      tbl[8]  = '{1'b1,1'b1,16'h5303,16'h0206,1'b0,1'b1,1'b0, 1'b1,16'h5101,16'h0202,1'b0,2'd2,1'b0};
      tbl[9]  = '{1'b1,1'b1,16'h5303,16'h0206,1'b0,1'b0,1'b0, 1'b1,16'h5202,16'h0204,1'b0,2'd1,1'b1};
      tbl[10] = '{1'b1,1'b1,16'h5303,16'h0206,1'b0,1'b0,1'b0, 1'b1,16'h5303,16'h0206,1'b0,2'd1,1'b1};
      tbl[11] = '{1'b1,1'b0,16'h0000,16'h0000,1'b0,1'b1,1'b0, 1'b1,16'h5303,16'h0206,1'b0,2'd1,1'b1};
      tbl[12] = '{1'b1,1'b1,16'h7101,16'h0302,1'b0,1'b1,1'b0, 1'b1,16'h5303,16'h0206,1'b0,2'd2,1'b0};
      tbl[13] = '{1'b1,1'b1,16'h7777,16'h0304,1'b0,1'b1,1'b1, 1'b0,16'h0800,16'h0000,1'b0,2'd0,1'b1};
      tbl[14] = '{1'b1,1'b0,16'h0000,16'h0000,1'b0,1'b0,1'b0, 1'b0,16'h0800,16'h0000,1'b0,2'd0,1'b1};
      tbl[15] = '{1'b1,1'b1,16'h6000,16'h0402,1'b1,1'b1,1'b0, 1'b1,16'h6000,16'h0402,1'b1,2'd1,1'b1};
      tbl[16] = '{1'b1,1'b1,16'h6100,16'h0404,1'b0,1'b0,1'b0, 1'b1,16'h6100,16'h0404,1'b0,2'd1,1'b1};
      tbl[17] = '{1'b1,1'b0,16'h0000,16'h0000,1'b0,1'b0,1'b0, 1'b0,16'h0800,16'h0000,1'b0,2'd0,1'b1};

      for (int i = 0; i < 18; i++) begin
         step(tbl[i].r, tbl[i].vf, tbl[i].ins, tbl[i].pc, tbl[i].e, tbl[i].st, tbl[i].fl);
         chk($sformatf("vec%0d.validD", i),    {31'd0, validD},    {31'd0, tbl[i].ev});
         chk($sformatf("vec%0d.instrD", i),    {16'd0, instrD},    {16'd0, tbl[i].ei});
         chk($sformatf("vec%0d.incPCD", i),    {16'd0, incPCD},    {16'd0, tbl[i].ep});
         chk($sformatf("vec%0d.errD", i),      {31'd0, errD},      {31'd0, tbl[i].ee});
         chk($sformatf("vec%0d.occupancy", i), {30'd0, occupancy}, {30'd0, tbl[i].eo});
         chk($sformatf("vec%0d.readyF", i),    {31'd0, readyF},    {31'd0, tbl[i].er});
         if (i < 2) chk($sformatf("vec%0d.bubbleCnt", i), {16'd0, bubbleCnt}, 32'd0);
      end

      // Bubble counter: 5 empty unstalled cycles count, 2 stalled ones do not.
      step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
      chk("bubble.after_reset", {16'd0, bubbleCnt}, 32'd0);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
`ifdef FDB_BUBBLE_CNT_EN
      chk("bubble.count", {16'd0, bubbleCnt}, 32'd5);
`else
      chk("bubble.count", {16'd0, bubbleCnt}, 32'd0);
`endif

      // Flush beats push and pop in the same cycle, then the buffer refills from empty.
      step(1'b1, 1'b1, 16'hA001, 16'h0A02, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 16'hA002, 16'h0A04, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 16'hA003, 16'h0A06, 1'b0, 1'b0, 1'b1);
      check_model("flush_full");
      step(1'b1, 1'b1, 16'hA004, 16'h0A08, 1'b0, 1'b1, 1'b0);
      check_model("after_flush");
      chk("after_flush.instr", {16'd0, instrD}, 32'h0000A004);

      for (int n = 0; n < 600; n++) begin
         logic        r, vf, e, st, fl;
         logic [15:0] ins, pcv;
         r   = ($urandom_range(0, 49) != 0);
         vf  = ($urandom_range(0, 3) != 0);
         st  = ($urandom_range(0, 2) == 0);
         fl  = ($urandom_range(0, 9) == 0);
         e   = ($urandom_range(0, 7) == 0);
         ins = 16'($urandom);
         pcv = 16'($urandom);
         step(r, vf, ins, pcv, e, st, fl);
         check_model($sformatf("rnd%0d", n));
      end

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
